mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits in the execute stage, beside the ALU.
- Its hi/lo outputs feed the 32-bit 4:1 write-back select mux (MFHI/MFLO paths).
- Its busy output feeds the hazard unit, which stalls the pipeline.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, FSM states and default latencies for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MIPS multiply/divide unit with architectural HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_sh_hi;
  logic [31:0]      r_sh_lo;
  logic             r_div0;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_div;
  logic [31:0] w_rt_div;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_is_div;
  logic        w_is_mult;
  logic        w_commit;
  logic        w_mt_ok;

  assign busy  = (r_state == ST_RUN);
  assign start = md_valid && (md_op <= MD_DIVU) && !busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

  assign w_is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign w_is_div  = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign w_commit  = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));
  assign w_mt_ok   = md_valid && !busy;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign w_prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign w_prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Signed divide on magnitudes: 0x80000000 / -1 falls out as 0x80000000 with no overflow case.
  assign w_a_mag  = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
  assign w_b_mag  = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
  assign w_b_div  = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_rt_div = (rt_data == 32'd0) ? 32'd1 : rt_data;
  assign w_mag_q  = w_a_mag / w_b_div;
  assign w_mag_r  = w_a_mag % w_b_div;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (md_op)
      MD_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      MD_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      MD_DIV: begin
        w_res_lo = (rs_data[31] ^ rt_data[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
        w_res_hi = rs_data[31] ? (~w_mag_r + 32'd1) : w_mag_r;
      end
      MD_DIVU: begin
        w_res_lo = rs_data / w_rt_div;
        w_res_hi = rs_data % w_rt_div;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_commit) w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_sh_hi <= 32'd0;
      r_sh_lo <= 32'd0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_cnt   <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        r_sh_hi <= w_res_hi;
        r_sh_lo <= w_res_lo;
        r_div0  <= w_is_div && (rt_data == 32'd0);
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      // Commit only happens in RUN and MT writes only outside it, so they never collide.
      if (w_commit && !r_div0) begin
        r_hi <= r_sh_hi;
        r_lo <= r_sh_lo;
      end else if (w_mt_ok && (md_op == MD_MTHI)) begin
        r_hi <= rs_data;
      end else if (w_mt_ok && (md_op == MD_MTLO)) begin
        r_lo <= rs_data;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          run_len = 0;
  logic        prev_reset = 1'b1;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_valid (md_valid),
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .start    (start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model result for ops 0..3 given current HI/LO.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] nh, output logic [31:0] nl);
    longint          sa, sb, sp, sq, sr;
    longint unsigned up;
    nh = m_hi;
    nl = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin
        sp = sa * sb;
        nh = sp[63:32];
        nl = sp[31:0];
      end
      3'd1: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        nh = up[63:32];
        nl = up[31:0];
      end
      3'd2: if (b != 32'd0) begin
        sq = sa / sb;
        sr = sa % sb;
        nh = sr[31:0];
        nl = sq[31:0];
      end
      3'd3: if (b != 32'd0) begin
        nh = a % b;
        nl = a / b;
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1; occupies exactly one clock cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_start, input logic track);
    exp_t        e;
    logic [31:0] nh, nl;
    md_valid = 1'b1;
    md_op    = op;
    rs_data  = a;
    rt_data  = b;
    #1;
    check_eq($sformatf("start_op%0d", op), {63'd0, start}, {63'd0, exp_start});
    if (exp_start && track) begin
      model_op(op, a, b, nh, nl);
      e.hi     = nh;
      e.lo     = nl;
      e.cycles = (op < 3'd2) ? 5 : 10;
      exp_q.push_back(e);
      m_hi = nh;
      m_lo = nl;
    end
    @(posedge clk);
    #1;
    md_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    check_eq("drain_timeout", {63'd0, k >= 60}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a falling busy edge (not caused by reset) is a commit.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      run_len++;
    end else if (run_len > 0) begin
      if (!prev_reset && !reset) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_commit", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("commit_hi", {32'd0, hi}, {32'd0, e.hi});
          check_eq("commit_lo", {32'd0, lo}, {32'd0, e.lo});
          check_eq("busy_cycles", 64'(run_len), 64'(e.cycles));
        end
      end
      run_len = 0;
    end
    prev_reset = reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    md_valid = 1'b0;
    md_op    = 3'd0;
    rs_data  = 32'd0;
    rt_data  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);

    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1);
    wait_done();
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1);
    wait_done();
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1);
    wait_done();
    issue(3'd3, 32'd7, 32'd2, 1'b1, 1'b1);
    wait_done();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done();

    issue(3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    m_hi = 32'h1234_5678;
    check_eq("mthi_hi", {32'd0, hi}, {32'd0, m_hi});
    check_eq("mthi_busy", {63'd0, busy}, 64'd0);
    issue(3'd5, 32'hCAFE_BABE, 32'd0, 1'b0, 1'b0);
    m_lo = 32'hCAFE_BABE;
    check_eq("mtlo_lo", {32'd0, lo}, {32'd0, m_lo});
    check_eq("mtlo_hi", {32'd0, hi}, {32'd0, m_hi});
    check_eq("mtlo_busy", {63'd0, busy}, 64'd0);
    issue(3'd2, 32'd5, 32'd0, 1'b1, 1'b1);
    wait_done();
    issue(3'd3, 32'd5, 32'd0, 1'b1, 1'b1);
    wait_done();

    issue(3'd0, 32'h0001_0003, 32'hFFFF_FFFD, 1'b1, 1'b1);
    issue(3'd5, 32'h0000_0001, 32'd0, 1'b0, 1'b0);
    issue(3'd3, 32'd9, 32'd3, 1'b0, 1'b0);
    wait_done();
    check_eq("lo_not_mtlo", {63'd0, lo == 32'h1}, 64'd0);

    issue(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
    check_eq("rsvd_hi", {32'd0, hi}, {32'd0, m_hi});
    check_eq("rsvd_lo", {32'd0, lo}, {32'd0, m_lo});

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      issue(op, a, b, 1'b1, 1'b1);
      wait_done();
    end

    issue(3'd2, 32'd100, 32'd7, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_hi", {32'd0, hi}, 64'd0);
    check_eq("abort_lo", {32'd0, lo}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("no_late_commit", {busy, hi, lo}, 65'd0);
    end

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
